// File: rtl/vga_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 timing constants, framebuffer geometry, test colours   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package vga_pkg;

  localparam int HPIXELS = 640;
  localparam int HFP     = 16;
  localparam int HSPULSE = 96;
  localparam int HBP     = 48;
  localparam int HTOTAL  = HPIXELS + HFP + HSPULSE + HBP;

  localparam int VPIXELS = 480;
  localparam int VFP     = 10;
  localparam int VSPULSE = 2;
  localparam int VBP     = 33;
  localparam int VTOTAL  = VPIXELS + VFP + VSPULSE + VBP;

  localparam int FB_W  = 32;
  localparam int FB_H  = 24;
  localparam int SCALE = 20;

  localparam logic [7:0] C_QUAD_TL = 8'h03;
  localparam logic [7:0] C_QUAD_BL = 8'h1C;
  localparam logic [7:0] C_QUAD_TR = 8'hE0;
  localparam logic [7:0] C_QUAD_BR = 8'hFF;

  function automatic logic [7:0] quad_color(input logic right, input logic bottom);
    case ({right, bottom})
      2'b00:   quad_color = C_QUAD_TL;
      2'b01:   quad_color = C_QUAD_BL;
      2'b10:   quad_color = C_QUAD_TR;
      default: quad_color = C_QUAD_BR;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_timing : h/v counters, raw sync/visible decode and frame pulses         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_visible,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_end,
  output logic       o_frame_end,
  output logic       o_frame_start,
  output logic       o_vblank_start
);

  localparam logic [9:0] C_H_LAST   = 10'(HTOTAL - 1);
  localparam logic [9:0] C_V_LAST   = 10'(VTOTAL - 1);
  localparam logic [9:0] C_H_VIS    = 10'(HPIXELS);
  localparam logic [9:0] C_V_VIS    = 10'(VPIXELS);
  localparam logic [9:0] C_HS_START = 10'(HPIXELS + HFP);
  localparam logic [9:0] C_HS_END   = 10'(HPIXELS + HFP + HSPULSE);
  localparam logic [9:0] C_VS_START = 10'(VPIXELS + VFP);
  localparam logic [9:0] C_VS_END   = 10'(VPIXELS + VFP + VSPULSE);

  logic [9:0] r_h;
  logic [9:0] r_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == C_H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == C_V_LAST) ? 10'd0 : r_v + 10'd1;
    end else begin
      r_h <= r_h + 10'd1;
    end
  end

  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_visible   = (r_h < C_H_VIS) && (r_v < C_V_VIS);
  assign o_hsync     = (r_h >= C_HS_START) && (r_h < C_HS_END);
  assign o_vsync     = (r_v >= C_VS_START) && (r_v < C_VS_END);
  assign o_line_end  = (r_h == C_H_LAST);
  assign o_frame_end = (r_h == C_H_LAST) && (r_v == C_V_LAST);

  // Pulses are masked while reset is held so the first released cycle carries frame_start.
  assign o_frame_start  = !reset && (r_h == 10'd0) && (r_v == 10'd0);
  assign o_vblank_start = !reset && (r_h == 10'd0) && (r_v == C_V_VIS);

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vga_scanout : 32x24 framebuffer scan-out, 20x scaling, quadrant test mode   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module vga_scanout
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pattern_en,
  output logic [19:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [9:0]  h,
  output logic [9:0]  v,
  output logic [7:0]  color,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        de,
  output logic        frame_start,
  output logic        vblank_start
);

  localparam logic [9:0] C_H_ADV_MAX = 10'(HPIXELS - 1);
  localparam logic [9:0] C_V_ADV_MAX = 10'(VPIXELS - 1);
  localparam logic [4:0] C_SUB_LAST  = 5'(SCALE - 1);
  localparam logic [4:0] C_CX_HALF   = 5'(FB_W / 2);
  localparam logic [4:0] C_CY_HALF   = 5'(FB_H / 2);

  logic w_visible, w_hsync, w_vsync, w_line_end, w_frame_end;
  logic w_h_adv, w_v_adv, w_pat_eff;

  logic [4:0] r_hsub, r_cx, r_vsub, r_cy;
  logic       r_pattern;
  logic       r_de1, r_hs_n1, r_vs_n1, r_pat1;
  logic [7:0] r_pcolor1;
  logic [7:0] r_color;
  logic       r_hs_n2, r_vs_n2, r_de2;

  vga_timing u_timing (
    .clk            (clk),
    .reset          (reset),
    .o_h            (h),
    .o_v            (v),
    .o_visible      (w_visible),
    .o_hsync        (w_hsync),
    .o_vsync        (w_vsync),
    .o_line_end     (w_line_end),
    .o_frame_end    (w_frame_end),
    .o_frame_start  (frame_start),
    .o_vblank_start (vblank_start)
  );

  // Cell counters advance only on steps that stay inside the visible area.
  assign w_h_adv = (h < C_H_ADV_MAX);
  assign w_v_adv = (v < C_V_ADV_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsub <= '0;
      r_cx   <= '0;
      r_vsub <= '0;
      r_cy   <= '0;
    end else begin
      if (w_line_end) begin
        r_hsub <= '0;
        r_cx   <= '0;
      end else if (w_h_adv) begin
        if (r_hsub == C_SUB_LAST) begin
          r_hsub <= '0;
          r_cx   <= r_cx + 5'd1;
        end else begin
          r_hsub <= r_hsub + 5'd1;
        end
      end
      if (w_frame_end) begin
        r_vsub <= '0;
        r_cy   <= '0;
      end else if (w_line_end && w_v_adv) begin
        if (r_vsub == C_SUB_LAST) begin
          r_vsub <= '0;
          r_cy   <= r_cy + 5'd1;
        end else begin
          r_vsub <= r_vsub + 5'd1;
        end
      end
    end
  end

  assign rd_addr = w_visible ? {10'd0, r_cy, r_cx} : 20'd0;

  // The frame_start pixel already belongs to the new frame, so it sees the fresh select.
  assign w_pat_eff = frame_start ? pattern_en : r_pattern;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= 1'b0;
      r_de1     <= 1'b0;
      r_hs_n1   <= 1'b1;
      r_vs_n1   <= 1'b1;
      r_pat1    <= 1'b0;
      r_pcolor1 <= '0;
      r_color   <= '0;
      r_hs_n2   <= 1'b1;
      r_vs_n2   <= 1'b1;
      r_de2     <= 1'b0;
    end else begin
      if (frame_start) begin
        r_pattern <= pattern_en;
      end
      r_de1     <= w_visible;
      r_hs_n1   <= !w_hsync;
      r_vs_n1   <= !w_vsync;
      r_pat1    <= w_pat_eff;
      r_pcolor1 <= quad_color(r_cx >= C_CX_HALF, r_cy >= C_CY_HALF);
      r_color   <= r_de1 ? (r_pat1 ? r_pcolor1 : rd_data) : 8'h00;
      r_hs_n2   <= r_hs_n1;
      r_vs_n2   <= r_vs_n1;
      r_de2     <= r_de1;
    end
  end

  assign color   = r_color;
  assign hsync_n = r_hs_n2;
  assign vsync_n = r_vs_n2;
  assign de      = r_de2;

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have port clk, input, 1, single system/pixel clock; all logic rising-edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port pattern_en, input, 1, test-pattern select, sampled per frame.
REQ-004 SHALL have port rd_addr, output, 20, framebuffer read address.
REQ-005 SHALL have port rd_data, input, 8, framebuffer pixel RGB332; registered RAM, 1-cycle read latency.
REQ-006 SHALL have port h, output, 10, current horizontal counter.
REQ-007 SHALL have port v, output, 10, current vertical counter.
REQ-008 SHALL have port color, output, 8, RGB332 pixel to DAC.
REQ-009 SHALL have port hsync_n, output, 1, horizontal sync, active low.
REQ-010 SHALL have port vsync_n, output, 1, vertical sync, active low.
REQ-011 SHALL have port de, output, 1, display enable (visible pixel).
REQ-012 SHALL have port frame_start, output, 1, 1-cycle pulse at h=0,v=0.
REQ-013 SHALL have port vblank_start, output, 1, 1-cycle pulse at h=0,v=480; signals the writer that the framebuffer may be updated.

Function
REQ-014 h SHALL count 0..799 and wrap to 0; v SHALL increment when h wraps, count 0..524 and wrap to 0.
REQ-015 Visible region SHALL be h<640 and v<480; hsync active for h in 656..751; vsync active for v in 490..491.
REQ-016 Framebuffer SHALL be 32x24 cells, each covering 20x20 screen pixels.
REQ-017 Cell column cx and row cy SHALL come from sub-counters (0..19) plus cell counters; no divider allowed.
REQ-018 rd_addr SHALL equal cy*32+cx while visible and 0 otherwise, combinational from the registered counters in cycle t.
REQ-019 color, hsync_n, vsync_n and de SHALL be registered and delayed exactly 2 cycles from the h/v values that produced them.
REQ-020 color SHALL be 0 whenever the delayed de is 0.
REQ-021 With pattern active, color SHALL be the quadrant pattern and ignore rd_data:
  - cx<16, cy<12 -> 0x03
  - cx<16, cy>=12 -> 0x1C
  - cx>=16, cy<12 -> 0xE0
  - otherwise -> 0xFF
REQ-022 pattern_en SHALL be latched only in the frame_start cycle; a mid-frame change takes effect at the next frame.
REQ-023 frame_start and vblank_start SHALL be aligned with h/v, not with the 2-cycle pipeline.
REQ-024 Cell counters SHALL reset to 0 at h=0 (cx) and v=0 (cy); they SHALL be held outside the visible region.

Reset
REQ-025 On reset, h=0, v=0, all sub-counters and cell counters SHALL be 0, the latched pattern SHALL be 0, color=0, hsync_n=1, vsync_n=1, de=0, frame_start=0 and vblank_start=0.
REQ-026 Reset mid-frame SHALL abort immediately, flush the pipeline to idle values, and make the first post-reset cycle h=0,v=0 with frame_start=1.

Structure
REQ-027 Package vga_pkg SHALL hold:
  - all timing constants (HPIXELS, HFP, HSPULSE, HBP, VPIXELS, VFP, VSPULSE, VBP);
  - FB_W=32, FB_H=24, SCALE=20;
  - RGB332 quadrant colour constants.
REQ-028 Sub-module vga_timing SHALL hold the h/v counters, raw sync/visible decode and the frame pulses; vga_scanout SHALL add cell mapping, address generation, pattern mux and the output pipeline.

Verification
REQ-029 Reset mid-frame: assert reset at h=300,v=100 -> next cycle h=0, v=0, hsync_n=1, vsync_n=1, de=0, color=0; frame_start=1 on first cycle after release.
REQ-030 Line/frame timing: free-run -> line period 800 cycles; hsync_n low 96 cycles, first low 2 cycles after h=656; vsync_n low 1600 cycles; frame_start every 420000 cycles.
REQ-031 Address map: (h,v)=(0,0) -> rd_addr 0; (20,19) -> 1; (0,20) -> 32; (639,479) -> 767; (640,0) or (0,480) -> 0.
REQ-032 Data path: RAM model returns addr[7:0] -> at h=40,v=40 (addr 66) color=66 two cycles later; color=0 through every blanking cycle.
REQ-033 Pattern: raise pattern_en at v=200 -> current frame still shows RAM data; next frame shows (10,10) -> 0x03, (10,300) -> 0x1C, (400,10) -> 0xE0, (400,300) -> 0xFF.
